mult_controller: RTL

MULT_CONTROLLER -- requirements
Module: mult_controller

---
 rtl/mult_pkg.sv | 13 +
 rtl/mult_if.sv | 23 ++
 rtl/mult_iter_cnt.sv | 40 ++++
 rtl/mult_controller.sv | 111 +++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and default sizing for the shift/add multiply controller.
package mult_pkg;

    localparam int unsigned IterDefault   = 16;
    localparam int unsigned WidthCDefault = 4;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

endpackage

// File: rtl/mult_if.sv
// Operand/product valid-ready handshake between the controller and its neighbours.
interface mult_if;

    logic src_valid;
    logic src_ready;
    logic dst_valid;
    logic dst_ready;

    modport master (
        output src_valid,
        output dst_ready,
        input  src_ready,
        input  dst_valid
    );

    modport slave (
        input  src_valid,
        input  dst_ready,
        output src_ready,
        output dst_valid
    );

endinterface

// File: rtl/mult_iter_cnt.sv
// Iteration counter for the multiply sequencer; clear wins over enable, wraps after ITER-1.
module mult_iter_cnt
    import mult_pkg::*;
#(
    parameter int unsigned ITER    = IterDefault,
    parameter int unsigned WIDTH_C = WidthCDefault
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               enable,
    output logic [WIDTH_C-1:0] count,
    output logic               last
);

    localparam logic [WIDTH_C-1:0] LastVal = WIDTH_C'(ITER - 1);

    logic [WIDTH_C-1:0] count_d, count_q;

    assign last  = (count_q == LastVal);
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = last ? '0 : count_q + WIDTH_C'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mult_controller.sv
// Sequencer for an iterative shift/add multiplier: IDLE -> CALC (ITER cycles) -> DONE.
// Define MULT_ZERO_SKIP_EN to jump straight to DONE when an operand is zero.
module mult_controller
    import mult_pkg::*;
#(
    parameter int unsigned ITER    = IterDefault,
    parameter int unsigned WIDTH_C = WidthCDefault
) (
    input  logic clk,
    input  logic reset,
    mult_if.slave hs,
    input  logic mult_lsb,
    input  logic count_check,
    input  logic empty,
    output logic load_words,
    output logic flush,
    output logic add_shift,
    output logic shift,
    output logic ready,
    output logic busy,
    output logic err
);

    state_e state_d, state_q;
    logic   err_d, err_q;
    logic   cnt_clear, cnt_en, cnt_last;
    logic [WIDTH_C-1:0] iter_cnt;

`ifndef MULT_ZERO_SKIP_EN
    logic unused_empty;
    assign unused_empty = empty;
`endif

    mult_iter_cnt #(
        .ITER    (ITER),
        .WIDTH_C (WIDTH_C)
    ) u_iter_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .count  (iter_cnt),
        .last   (cnt_last)
    );

    assign err = err_q;

    // IDLE-side outputs are gated by reset so everything reads 0 while reset is held.
    always_comb begin
        state_d      = state_q;
        err_d        = err_q;
        cnt_clear    = 1'b0;
        cnt_en       = 1'b0;
        hs.src_ready = 1'b0;
        hs.dst_valid = 1'b0;
        load_words   = 1'b0;
        flush        = 1'b0;
        add_shift    = 1'b0;
        shift        = 1'b0;
        ready        = 1'b0;
        busy         = 1'b0;
        unique case (state_q)
            StIdle: begin
                hs.src_ready = reset;
                if (hs.src_valid && reset) begin
                    load_words = 1'b1;
                    flush      = 1'b1;
                    cnt_clear  = 1'b1;
                    state_d    = StCalc;
`ifdef MULT_ZERO_SKIP_EN
                    if (empty) begin
                        state_d = StDone;
                    end
`endif
                end
            end
            StCalc: begin
                busy      = 1'b1;
                add_shift = mult_lsb;
                shift     = ~mult_lsb;
                cnt_en    = 1'b1;
                if (count_check != cnt_last) begin
                    err_d = 1'b1;
                end
                if (cnt_last) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                busy         = 1'b1;
                hs.dst_valid = 1'b1;
                ready        = 1'b1;
                if (hs.dst_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

endmodule
